// File: rtl/massbus_switch_if.sv
// massbus_switch_if: RH11 master side and per-drive slave side signals of the Massbus switch
interface massbus_switch_if #(
  parameter int NDRV = 8,
  parameter int DW = 36
);
  logic mbINIT, mbREAD, mbWRITE, mbGO, mbACKI;
  logic [2:0] mbUNIT;
  logic mbREQO;
  logic [DW-1:0] mbDATAO;
  logic [15:0] mbREGDAT;
  logic mbREGACK, mbNXD;
  logic mbINCBA, mbDECBA, mbINCWC, mbWCE, mbNPRO;
  logic [7:0] mbATA;
  logic mbDVA, mbDPR, mbDRY, mbACLO;
  logic [NDRV-1:0] drvINIT, drvREAD, drvWRITE, drvACKI, drvGO;
  logic [NDRV-1:0] drvREQO, drvREGACK, drvACLO, drvATA, drvDVA, drvDPR, drvDRY;
  logic [NDRV-1:0] drvINCBA, drvDECBA, drvINCWC, drvWCE, drvNPRO;
  logic [NDRV*DW-1:0] drvDATAO;
  logic [NDRV*16-1:0] drvREGDAT;
  modport slave (
    input mbINIT, mbREAD, mbWRITE, mbUNIT, mbGO, mbACKI,
    input drvREQO, drvREGACK, drvACLO, drvATA, drvDVA, drvDPR, drvDRY,
    input drvINCBA, drvDECBA, drvINCWC, drvWCE, drvNPRO, drvDATAO, drvREGDAT,
    output mbREQO, mbDATAO, mbREGDAT, mbREGACK, mbNXD,
    output mbINCBA, mbDECBA, mbINCWC, mbWCE, mbNPRO,
    output mbATA, mbDVA, mbDPR, mbDRY, mbACLO,
    output drvINIT, drvREAD, drvWRITE, drvACKI, drvGO
  );
  modport master (
    output mbINIT, mbREAD, mbWRITE, mbUNIT, mbGO, mbACKI,
    output drvREQO, drvREGACK, drvACLO, drvATA, drvDVA, drvDPR, drvDRY,
    output drvINCBA, drvDECBA, drvINCWC, drvWCE, drvNPRO, drvDATAO, drvREGDAT,
    input mbREQO, mbDATAO, mbREGDAT, mbREGACK, mbNXD,
    input mbINCBA, mbDECBA, mbINCWC, mbWCE, mbNPRO,
    input mbATA, mbDVA, mbDPR, mbDRY, mbACLO,
    input drvINIT, drvREAD, drvWRITE, drvACKI, drvGO
  );
endinterface

// File: rtl/massbus_switch.sv
// massbus_switch: fans one RH11 Massbus master out to NDRV drives (register cycles, transfer owner, status merge)
module massbus_switch #(
  parameter int NDRV = 8,
  parameter int TMO = 15,
  parameter int DW = 36
) (
  input logic clk,
  input logic rst,
  massbus_switch_if.slave bus
);
  localparam int TW = $clog2(TMO);
  localparam logic [1:0] IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [2:0] unit, owner;
  logic isWrite, nxd, ownerValid, dryPrev, goFwd, dryRise, toDone, clr;
  logic [TW-1:0] timer;
  logic [7:0] dprP, dvaP, dryP, reqP, ackP, incbaP, decbaP, incwcP, wceP, nproP;
  logic [7:0] unitHot, goHot, ownHot;
  logic [DW-1:0] dataArr [8];
  logic [15:0] regArr [8];
  assign dprP = 8'(bus.drvDPR);
  assign dvaP = 8'(bus.drvDVA);
  assign dryP = 8'(bus.drvDRY);
  assign reqP = 8'(bus.drvREQO);
  assign ackP = 8'(bus.drvREGACK);
  assign incbaP = 8'(bus.drvINCBA);
  assign decbaP = 8'(bus.drvDECBA);
  assign incwcP = 8'(bus.drvINCWC);
  assign wceP = 8'(bus.drvWCE);
  assign nproP = 8'(bus.drvNPRO);
  for (genvar g = 0; g < 8; g++) begin : pad
    if (g < NDRV) begin : live
      assign dataArr[g] = bus.drvDATAO[g*DW +: DW];
      assign regArr[g] = bus.drvREGDAT[g*16 +: 16];
    end else begin : dead
      assign dataArr[g] = '0;
      assign regArr[g] = '0;
    end
  end
  assign unitHot = 8'd1 << unit;
  assign goHot = 8'd1 << bus.mbUNIT;
  assign ownHot = 8'd1 << owner;
  assign clr = rst | bus.mbINIT;
  assign goFwd = bus.mbGO & dprP[bus.mbUNIT];
  assign dryRise = ownerValid & dryP[owner] & ~dryPrev;
  assign toDone = ~bus.mbINIT & ((state == STROBE & ~dprP[unit]) |
                  (state == WAIT & (ackP[unit] | timer == TW'(TMO - 1))));
  // register-cycle sequencer: latch request, strobe the drive, wait for ack or timeout
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      unit <= '0;
      isWrite <= 1'b0;
      nxd <= 1'b0;
      timer <= '0;
      bus.drvREAD <= '0;
      bus.drvWRITE <= '0;
    end else begin
      bus.drvREAD <= '0;
      bus.drvWRITE <= '0;
      if (state == IDLE && (bus.mbREAD || bus.mbWRITE)) begin
        unit <= bus.mbUNIT;
        isWrite <= bus.mbWRITE;
        state <= STROBE;
      end else if (state == STROBE) begin
        nxd <= ~dprP[unit];
        timer <= '0;
        state <= dprP[unit] ? WAIT : DONE;
        bus.drvREAD <= (dprP[unit] && !isWrite) ? unitHot[NDRV-1:0] : '0;
        bus.drvWRITE <= (dprP[unit] && isWrite) ? unitHot[NDRV-1:0] : '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
        if (ackP[unit]) begin
          state <= DONE;
          nxd <= 1'b0;
        end else if (timer == TW'(TMO - 1)) begin
          state <= DONE;
          nxd <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  // read data is captured on entry to DONE and held; only a true reset clears it
  always_ff @(posedge clk) begin
    if (rst) bus.mbREGDAT <= '0;
    else if (toDone) bus.mbREGDAT <= (state == WAIT && ackP[unit] && !isWrite) ? regArr[unit] : '0;
  end
  // transfer owner: taken by the first forwarded GO, dropped when the owner's DRY rises
  always_ff @(posedge clk) begin
    if (clr) begin
      ownerValid <= 1'b0;
      owner <= '0;
      dryPrev <= 1'b0;
    end else begin
      dryPrev <= dryP[owner];
      if (dryRise) ownerValid <= 1'b0;
      else if (goFwd && !ownerValid) begin
        ownerValid <= 1'b1;
        owner <= bus.mbUNIT;
        dryPrev <= dryP[bus.mbUNIT];
      end
    end
  end
  assign bus.mbREGACK = state == DONE;
  assign bus.mbNXD = state == DONE && nxd;
  assign bus.drvINIT = {NDRV{bus.mbINIT}};
  assign bus.drvGO = goFwd ? goHot[NDRV-1:0] : '0;
  assign bus.drvACKI = (ownerValid && bus.mbACKI) ? ownHot[NDRV-1:0] : '0;
  assign bus.mbREQO = ownerValid & reqP[owner];
  assign bus.mbDATAO = ownerValid ? dataArr[owner] : '0;
  assign bus.mbINCBA = ownerValid & incbaP[owner];
  assign bus.mbDECBA = ownerValid & decbaP[owner];
  assign bus.mbINCWC = ownerValid & incwcP[owner];
  assign bus.mbWCE = ownerValid & wceP[owner];
  assign bus.mbNPRO = ownerValid & nproP[owner];
  assign bus.mbATA = 8'(bus.drvATA);
  assign bus.mbDVA = dvaP[bus.mbUNIT];
  assign bus.mbDPR = dprP[bus.mbUNIT];
  assign bus.mbDRY = dryP[bus.mbUNIT];
  assign bus.mbACLO = |bus.drvACLO;
endmodule

// File: tb/tb_massbus_switch.sv
// tb_massbus_switch: random Massbus traffic checked against a timeline model of register cycles and transfer ownership
module tb_massbus_switch;
  localparam int NDRV = 4, TMO = 15, DW = 36;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  massbus_switch_if #(.NDRV(NDRV), .DW(DW)) bus ();
  massbus_switch #(.NDRV(NDRV), .TMO(TMO), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  bit pend = 0, pres = 0, pWr = 0, pNxd = 0, own = 0;
  int c0 = 0, pUnit = 0, pDelay = 0, doneCyc = -1, owner = 0;
  logic [15:0] pData = '0, expRegdat = '0;
  logic [NDRV-1:0] prevDry = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic int pickDelay();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return $urandom_range(2, TMO - 2);
      3: return TMO - 1;
      4: return TMO;
      default: return 99;
    endcase
  endfunction
  task automatic drive();
    logic [NDRV-1:0] a;
    bus.mbINIT = (!rst && $urandom_range(0, 199) == 0);
    bus.mbREAD = ($urandom_range(0, 5) == 0);
    bus.mbWRITE = ($urandom_range(0, 7) == 0);
    bus.mbUNIT = 3'($urandom_range(0, 7));
    bus.mbGO = ($urandom_range(0, 9) == 0);
    bus.mbACKI = 1'($urandom);
    if ($urandom_range(0, 29) == 0) bus.drvDPR = NDRV'($urandom);
    bus.drvDRY = bus.drvDRY ^ NDRV'($urandom & $urandom);
    bus.drvREQO = NDRV'($urandom);
    bus.drvACLO = ($urandom_range(0, 3) == 0) ? NDRV'($urandom) : '0;
    bus.drvATA = NDRV'($urandom);
    bus.drvDVA = NDRV'($urandom);
    bus.drvINCBA = NDRV'($urandom);
    bus.drvDECBA = NDRV'($urandom);
    bus.drvINCWC = NDRV'($urandom);
    bus.drvWCE = NDRV'($urandom);
    bus.drvNPRO = NDRV'($urandom);
    for (int i = 0; i < NDRV; i++) begin
      bus.drvDATAO[i*DW +: DW] = DW'({$urandom, $urandom});
      bus.drvREGDAT[i*16 +: 16] = 16'($urandom);
    end
    a = NDRV'($urandom);
    if (pend && pUnit < NDRV) a[pUnit] = 1'b0;
    if (pend && pres && pDelay < TMO && cyc == c0 + 2 + pDelay) begin
      a[pUnit] = 1'b1;
      pData = pWr ? 16'h0 : bus.drvREGDAT[pUnit*16 +: 16];
    end
    bus.drvREGACK = a;
  endtask
  task automatic update();
    int u;
    bit wasIdle, go;
    u = int'(bus.mbUNIT);
    go = bus.mbGO && u < NDRV && bus.drvDPR[u];
    if (rst || bus.mbINIT) begin
      pend = 0;
      own = 0;
    end else begin
      wasIdle = !pend;
      if (pend && cyc == doneCyc) pend = 0;
      if (pend && cyc == c0 + 1) begin
        pres = pUnit < NDRV && bus.drvDPR[pUnit];
        doneCyc = !pres ? c0 + 2 : (pDelay < TMO ? c0 + 3 + pDelay : c0 + 2 + TMO);
        pNxd = !pres || pDelay >= TMO;
      end
      if (wasIdle && (bus.mbREAD || bus.mbWRITE)) begin
        pend = 1;
        c0 = cyc;
        pUnit = u;
        pWr = bus.mbWRITE;
        pDelay = pickDelay();
        pData = '0;
        doneCyc = -1;
      end
      if (own && bus.drvDRY[owner] && !prevDry[owner]) own = 0;
      else if (go && !own) begin
        own = 1;
        owner = u;
      end
    end
    prevDry = bus.drvDRY;
    if (rst) expRegdat = '0;
  endtask
  task automatic checkOutputs();
    int u;
    bit regack, go;
    logic [NDRV-1:0] expStrobe;
    u = int'(bus.mbUNIT);
    go = bus.mbGO && u < NDRV && bus.drvDPR[u];
    regack = pend && cyc == doneCyc;
    if (regack) expRegdat = pNxd ? 16'h0 : pData;
    expStrobe = (pend && pres && cyc == c0 + 2) ? NDRV'(1 << pUnit) : '0;
    check("drvREAD", bus.drvREAD, pWr ? '0 : expStrobe);
    check("drvWRITE", bus.drvWRITE, pWr ? expStrobe : '0);
    check("mbREGACK", bus.mbREGACK, regack);
    check("mbNXD", bus.mbNXD, regack && pNxd);
    check("mbREGDAT", bus.mbREGDAT, expRegdat);
    check("drvINIT", bus.drvINIT, bus.mbINIT ? {NDRV{1'b1}} : '0);
    check("drvGO", bus.drvGO, go ? NDRV'(1 << u) : '0);
    check("drvACKI", bus.drvACKI, (own && bus.mbACKI) ? NDRV'(1 << owner) : '0);
    check("mbREQO", bus.mbREQO, own && bus.drvREQO[owner]);
    check("mbDATAO", bus.mbDATAO, own ? bus.drvDATAO[owner*DW +: DW] : '0);
    check("mbINCBA", bus.mbINCBA, own && bus.drvINCBA[owner]);
    check("mbDECBA", bus.mbDECBA, own && bus.drvDECBA[owner]);
    check("mbINCWC", bus.mbINCWC, own && bus.drvINCWC[owner]);
    check("mbWCE", bus.mbWCE, own && bus.drvWCE[owner]);
    check("mbNPRO", bus.mbNPRO, own && bus.drvNPRO[owner]);
    check("mbATA", bus.mbATA, {4'b0, bus.drvATA});
    check("mbDVA", bus.mbDVA, u < NDRV && bus.drvDVA[u]);
    check("mbDPR", bus.mbDPR, u < NDRV && bus.drvDPR[u]);
    check("mbDRY", bus.mbDRY, u < NDRV && bus.drvDRY[u]);
    check("mbACLO", bus.mbACLO, bus.drvACLO != '0);
  endtask
  initial begin
    bus.drvDPR = NDRV'($urandom);
    bus.drvDRY = '0;
    drive();
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      update();
      #1;
      cyc++;
      rst = (cyc < 4);
      drive();
      @(negedge clk);
      checkOutputs();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
